// File: rtl/mac_acc_node.sv
// -----------------------------------------------------------------------------
// mac_acc_node
// Single-neuron multiply-accumulate node. Each clock, 16 unsigned pixel bytes
// are multiplied by 16 signed weight bytes and the products are summed. The
// partial sums are accumulated over a fixed 4-beat frame (64 inputs). On the
// last beat, a bias is added and a ReLU plus scale/saturate activation produces
// an 8-bit node output.
//
// Ports
//   clk   in   1    rising-edge clock
//   rst   in   1    synchronous reset, active-low
//   p     in   128  16 unsigned 8-bit pixel lanes, lane i = p[8i+7:8i]
//   w     in   128  16 signed 8-bit weight lanes,   lane i = w[8i+7:8i]
//   b     in   8    signed bias, only used on beat 3
//   dout  out  22   signed running accumulator of the current frame
//   out1  out  8    activated output of the last completed frame
// -----------------------------------------------------------------------------
module mac_acc_node (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] p,
  input  logic [127:0] w,
  input  logic [7:0]   b,
  output logic [21:0]  dout,
  output logic [7:0]   out1
);

  localparam logic [1:0] BEAT_FIRST = 2'd0;
  localparam logic [1:0] BEAT_MID1  = 2'd1;
  localparam logic [1:0] BEAT_MID2  = 2'd2;
  localparam logic [1:0] BEAT_LAST  = 2'd3;

  // Unsigned pixel times signed weight. Both operands are widened to 17 bits
  // as signed values. The true product range (-32640..32385) fits in 17 bits,
  // so keeping the low 17 bits of the product is exact.
  function automatic logic signed [16:0] lane_prod(input logic [7:0] pv,
                                                   input logic [7:0] wv);
    logic signed [16:0] pe;
    logic signed [16:0] we;
    pe = $signed({9'b0, pv});
    we = $signed({{9{wv[7]}}, wv});
    lane_prod = pe * we;
  endfunction

  logic [1:0]         beat_r;
  logic signed [21:0] dout_r;
  logic [7:0]         out1_r;

  logic signed [20:0] psum_s;
  logic signed [21:0] psum_ext_s;
  logic signed [21:0] total_s;
  logic signed [21:0] act_s;
  logic [21:0]        shr_s;
  logic [7:0]         act_out_s;

  // Sum of the 16 lane products for the current beat.
  always_comb begin
    logic signed [16:0] prod;
    psum_s = 21'sd0;
    for (int i = 0; i < 16; i++) begin
      prod   = lane_prod(p[8*i +: 8], w[8*i +: 8]);
      psum_s = psum_s + {{4{prod[16]}}, prod};
    end
  end

  // Frame total on the last beat, bias, then ReLU with scale and saturation.
  always_comb begin
    psum_ext_s = {psum_s[20], psum_s};
    total_s    = dout_r + psum_ext_s;
    act_s      = total_s + {{14{b[7]}}, b};
    // The shift is logical. It is only used when act_s is non-negative.
    shr_s      = act_s >> 8;
    if (act_s[21]) begin
      act_out_s = 8'd0;
    end else if (shr_s > 22'd255) begin
      act_out_s = 8'd255;
    end else begin
      act_out_s = shr_s[7:0];
    end
  end

  // Beat counter, frame accumulator and activated output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_r <= BEAT_FIRST;
      dout_r <= 22'sd0;
      out1_r <= 8'd0;
    end else begin
      beat_r <= beat_r + 2'd1;
      case (beat_r)
        BEAT_FIRST: begin
          // A new frame starts here, and the previous accumulation is dropped.
          dout_r <= psum_ext_s;
          out1_r <= out1_r;
        end
        BEAT_MID1, BEAT_MID2: begin
          dout_r <= total_s;
          out1_r <= out1_r;
        end
        BEAT_LAST: begin
          dout_r <= total_s;
          out1_r <= act_out_s;
        end
        default: begin
          dout_r <= 22'sd0;
          out1_r <= 8'd0;
        end
      endcase
    end
  end

  assign dout = dout_r;
  assign out1 = out1_r;

endmodule

// File: tb/tb_mac_acc_node.sv
// -----------------------------------------------------------------------------
// tb_mac_acc_node
// Directed scoreboard bench for mac_acc_node. Each clock, the driver applies
// one vector and pushes the hand-computed dout/out1 expected after that edge.
// A separate monitor samples the DUT 1ns after each rising edge and pops and
// compares the expected values.
// -----------------------------------------------------------------------------
module tb_mac_acc_node;

  typedef struct {
    int                 idx;
    logic signed [21:0] exp_dout;
    logic [7:0]         exp_out1;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [127:0] p;
  logic [127:0] w;
  logic [7:0]   b;
  logic [21:0]  dout;
  logic [7:0]   out1;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   step_idx;
  bit   mon_done;

  mac_acc_node dut (
    .clk  (clk),
    .rst  (rst),
    .p    (p),
    .w    (w),
    .b    (b),
    .dout (dout),
    .out1 (out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rep(input logic [7:0] v);
    rep = {16{v}};
  endfunction

  // Apply one beat's inputs before the next rising edge.
  // Queue the values expected just after that edge.
  task automatic step(input logic r, input logic [127:0] pv, input logic [127:0] wv,
                      input logic [7:0] bv, input logic signed [21:0] ed,
                      input logic [7:0] eo);
    exp_t e;
    @(negedge clk);
    rst = r;
    p   = pv;
    w   = wv;
    b   = bv;
    e.idx      = step_idx;
    e.exp_dout = ed;
    e.exp_out1 = eo;
    sb.push_back(e);
    step_idx++;
  endtask

  // Monitor: compare each DUT output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (dout !== e.exp_dout) begin
          errors++;
          $display("FAIL dout step %0d: actual=%0d required=%0d", e.idx,
                   $signed(dout), e.exp_dout);
        end
        checks++;
        if (out1 !== e.exp_out1) begin
          errors++;
          $display("FAIL out1 step %0d: actual=0x%02h required=0x%02h", e.idx,
                   out1, e.exp_out1);
        end
      end
    end
  end

  initial begin
    logic [127:0] pc;
    logic [127:0] wc;
    int           wait_cyc;
    checks   = 0;
    errors   = 0;
    step_idx = 0;
    mon_done = 1'b0;
    rst = 1'b0;
    p   = 128'd0;
    w   = 128'd0;
    b   = 8'd0;

    // Reset held for 3 clocks with arbitrary data.
    for (int i = 0; i < 3; i++)
      step(1'b0, {4{$urandom()}}, {4{$urandom()}}, 8'($urandom()), 22'sd0, 8'h00);

    // Positive frame: psum 4096 per beat, total 16384 + 11, >>8 = 0x40.
    step(1'b1, rep(8'h10), rep(8'h10), 8'd11, 22'sh001000, 8'h00);
    step(1'b1, rep(8'h10), rep(8'h10), 8'd11, 22'sh002000, 8'h00);
    step(1'b1, rep(8'h10), rep(8'h10), 8'd11, 22'sh003000, 8'h00);
    step(1'b1, rep(8'h10), rep(8'h10), 8'd11, 22'sh004000, 8'h40);

    // Saturation: psum 518160 per beat. out1 holds 0x40 until this frame ends.
    step(1'b1, rep(8'hFF), rep(8'h7F), 8'd0, 22'sd518160,  8'h40);
    step(1'b1, rep(8'hFF), rep(8'h7F), 8'd0, 22'sd1036320, 8'h40);
    step(1'b1, rep(8'hFF), rep(8'h7F), 8'd0, 22'sd1554480, 8'h40);
    step(1'b1, rep(8'hFF), rep(8'h7F), 8'd0, 22'sd2072640, 8'hFF);

    // ReLU: psum -522240 per beat.
    step(1'b1, rep(8'hFF), rep(8'h80), 8'd0, -22'sd522240,  8'hFF);
    step(1'b1, rep(8'hFF), rep(8'h80), 8'd0, -22'sd1044480, 8'hFF);
    step(1'b1, rep(8'hFF), rep(8'h80), 8'd0, -22'sd1566720, 8'hFF);
    step(1'b1, rep(8'hFF), rep(8'h80), 8'd0, -22'sd2088960, 8'h00);

    // Bias boundary, b=0 on beat 3 (b on beats 0..2 must be ignored): 256 -> 1.
    step(1'b1, rep(8'h04), rep(8'h01), 8'h7F, 22'sd64,  8'h00);
    step(1'b1, rep(8'h04), rep(8'h01), 8'h7F, 22'sd128, 8'h00);
    step(1'b1, rep(8'h04), rep(8'h01), 8'h7F, 22'sd192, 8'h00);
    step(1'b1, rep(8'h04), rep(8'h01), 8'h00, 22'sd256, 8'h01);

    // Bias boundary, b=-1 on beat 3: 255 -> 0.
    step(1'b1, rep(8'h04), rep(8'h01), 8'h7F, 22'sd64,  8'h01);
    step(1'b1, rep(8'h04), rep(8'h01), 8'h7F, 22'sd128, 8'h01);
    step(1'b1, rep(8'h04), rep(8'h01), 8'h7F, 22'sd192, 8'h01);
    step(1'b1, rep(8'h04), rep(8'h01), 8'hFF, 22'sd256, 8'h00);

    // Load out1 = 0x40, then reset on beat 2 of the next frame.
    step(1'b1, rep(8'h10), rep(8'h10), 8'd11, 22'sh001000, 8'h00);
    step(1'b1, rep(8'h10), rep(8'h10), 8'd11, 22'sh002000, 8'h00);
    step(1'b1, rep(8'h10), rep(8'h10), 8'd11, 22'sh003000, 8'h00);
    step(1'b1, rep(8'h10), rep(8'h10), 8'd11, 22'sh004000, 8'h40);
    step(1'b1, rep(8'h10), rep(8'h10), 8'd11, 22'sh001000, 8'h40);
    step(1'b1, rep(8'h10), rep(8'h10), 8'd11, 22'sh002000, 8'h40);
    step(1'b0, rep(8'h10), rep(8'h10), 8'd11, 22'sd0,      8'h00);

    // Back-to-back frames after release. Frame A: psum 384, total 1536 -> 6.
    step(1'b1, rep(8'h08), rep(8'h03), 8'h00, 22'sd384,  8'h00);
    step(1'b1, rep(8'h08), rep(8'h03), 8'h00, 22'sd768,  8'h00);
    step(1'b1, rep(8'h08), rep(8'h03), 8'h00, 22'sd1152, 8'h00);
    step(1'b1, rep(8'h08), rep(8'h03), 8'h00, 22'sd1536, 8'h06);
    // Frame B: psum -64, total -256 + 127 = -129 -> 0.
    step(1'b1, rep(8'h02), rep(8'hFE), 8'h00, -22'sd64,  8'h06);
    step(1'b1, rep(8'h02), rep(8'hFE), 8'h00, -22'sd128, 8'h06);
    step(1'b1, rep(8'h02), rep(8'hFE), 8'h00, -22'sd192, 8'h06);
    step(1'b1, rep(8'h02), rep(8'hFE), 8'h7F, -22'sd256, 8'h00);

    // Frame C, distinct lanes: p_i = i+1, w_i = 1 except w_15 = 16.
    // psum = (1+..+15) + 16*16 = 376. Total 1504 + 32 = 1536 -> 6.
    for (int i = 0; i < 16; i++) begin
      pc[8*i +: 8] = 8'(i + 1);
      wc[8*i +: 8] = (i == 15) ? 8'h10 : 8'h01;
    end
    step(1'b1, pc, wc, 8'h80, 22'sd376,  8'h00);
    step(1'b1, pc, wc, 8'h80, 22'sd752,  8'h00);
    step(1'b1, pc, wc, 8'h80, 22'sd1128, 8'h00);
    step(1'b1, pc, wc, 8'h20, 22'sd1504, 8'h06);

    // Let the monitor drain the queue, with a bounded wait.
    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d pending required=0 pending", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
